// File: rtl/func_bist.sv
// Self-test sequencer: drives LFSR operand pairs into func and folds each result into an 8-bit MISR.
// One operation in flight at a time; waits on f_busy_i per vector, watchdog aborts a hung datapath.
module func_bist #(
  parameter int unsigned N_VEC   = 16,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] sig_o,
  output logic [7:0] vec_cnt_o,
  output logic [7:0] f_a_o,
  output logic [7:0] f_b_o,
  output logic       f_start_o,
  input  logic       f_busy_i,
  input  logic [7:0] f_y_i
);

  localparam logic [7:0] VEC_LAST = 8'(N_VEC);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  sig_q, sig_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        err_q, err_d;
  logic        fstart_q, fstart_d;
  logic        done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      sig_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
      fstart_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      err_q    <= err_d;
      fstart_q <= fstart_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    fstart_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          lfsr_d  = SEED;
          sig_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        a_d      = lfsr_q[15:8];
        b_d      = lfsr_q[7:0];
        fstart_d = 1'b1;
        tmo_d    = '0;
        state_d  = S_WAIT_RISE;
      end
      // The watchdog budget is shared by both wait states of one operation.
      S_WAIT_RISE, S_WAIT_FALL: begin
        if ((state_q == S_WAIT_RISE) && f_busy_i) begin
          state_d = S_WAIT_FALL;
        end else if ((state_q == S_WAIT_FALL) && !f_busy_i) begin
          sig_d   = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3]} ^ f_y_i;
          cnt_d   = cnt_q + 8'd1;
          state_d = S_NEXT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_NEXT: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (cnt_q == VEC_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_START;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign sig_o     = sig_q;
  assign vec_cnt_o = cnt_q;
  assign f_a_o     = a_q;
  assign f_b_o     = b_q;
  assign f_start_o = fstart_q;

endmodule
